// File: rtl/cam_init_sequencer.sv
// Camera init sequencer: walks a {reg,value} table and issues SCCB writes via a
// req/done handshake, with NACK retry, delay entries and sticky done/error flags.
module cam_init_sequencer #(
  parameter int          ADDR_W       = 6,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter logic [23:0] DELAY_CYCLES = 24'd1_000_000,
  parameter int          MAX_RETRY    = 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              i2c_req,
  output logic [7:0]        i2c_dev,
  output logic [7:0]        i2c_reg,
  output logic [7:0]        i2c_wdata,
  input  logic              i2c_done,
  input  logic              i2c_nack,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_FIN, S_ERR
  } state_t;

  state_t        state, state_nx;
  logic [RW-1:0] retry;
  logic [23:0]   dly_cnt;
  logic          last_entry;
  logic          is_end, is_delay;

  assign last_entry = (rom_addr == LAST_ADDR);
  assign is_end     = (rom_data == 16'hFFFF);
  assign is_delay   = (rom_data == 16'hFFF0);

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        if (is_end)        state_nx = S_FIN;
        else if (is_delay) state_nx = S_DELAY;
        else               state_nx = S_ISSUE;
      end
      S_ISSUE:  state_nx = S_WAIT;
      S_WAIT: begin
        if (i2c_done) begin
          if (!i2c_nack)              state_nx = last_entry ? S_FIN : S_FETCH;
          else if (retry < RETRY_MAX) state_nx = S_ISSUE;
          else                        state_nx = S_ERR;
        end
      end
      S_DELAY:  if (dly_cnt == 24'd0) state_nx = last_entry ? S_FIN : S_FETCH;
      S_FIN:    state_nx = S_IDLE;
      S_ERR:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Datapath: table pointer, latched write, counters and sticky flags
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rom_addr  <= '0;
      i2c_reg   <= 8'h00;
      i2c_wdata <= 8'h00;
      retry     <= '0;
      dly_cnt   <= 24'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          rom_addr <= '0;
          busy     <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
        end
        S_DECODE: begin
          if (is_delay) begin
            dly_cnt <= DELAY_CYCLES - 24'd1;
          end else if (!is_end) begin
            i2c_reg   <= rom_data[15:8];
            i2c_wdata <= rom_data[7:0];
            retry     <= '0;
          end
        end
        S_WAIT: if (i2c_done) begin
          if (!i2c_nack) begin
            if (!last_entry) rom_addr <= rom_addr + 1'b1;
          end else if (retry < RETRY_MAX) begin
            retry <= retry + 1'b1;
          end
        end
        S_DELAY: begin
          if (dly_cnt == 24'd0) begin
            if (!last_entry) rom_addr <= rom_addr + 1'b1;
          end else begin
            dly_cnt <= dly_cnt - 24'd1;
          end
        end
        S_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        S_ERR: begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: a retry re-enters ISSUE with retry != 0, which yields the one-cycle req gap
  always_comb begin
    i2c_dev = DEV_ADDR;
    i2c_req = (state == S_WAIT) || ((state == S_ISSUE) && (retry == '0));
  end

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Directed bench for cam_init_sequencer: ROM and I2C master models, one task per scenario.
module tb_cam_init_sequencer;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic tb_clr = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: ADDR_W=6, short delay
  logic [5:0]  rom_addr0;
  logic [15:0] rom_data0;
  logic        req0, done_in0, nack_in0, busy0, donef0, err0;
  logic [7:0]  dev0, reg0, wd0;
  // DUT 1: ADDR_W=2, no end marker
  logic [1:0]  rom_addr1;
  logic [15:0] rom_data1;
  logic        req1, done_in1, nack_in1, busy1, donef1, err1;
  logic [7:0]  dev1, reg1, wd1;

  cam_init_sequencer #(.ADDR_W(6), .DEV_ADDR(8'h42), .DELAY_CYCLES(24'd100), .MAX_RETRY(3)) u0 (
    .clk(clk), .res(res), .start(start0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .i2c_req(req0), .i2c_dev(dev0), .i2c_reg(reg0), .i2c_wdata(wd0),
    .i2c_done(done_in0), .i2c_nack(nack_in0), .busy(busy0), .done(donef0), .error(err0));

  cam_init_sequencer #(.ADDR_W(2), .DEV_ADDR(8'h42), .DELAY_CYCLES(24'd4), .MAX_RETRY(3)) u1 (
    .clk(clk), .res(res), .start(start1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .i2c_req(req1), .i2c_dev(dev1), .i2c_reg(reg1), .i2c_wdata(wd1),
    .i2c_done(done_in1), .i2c_nack(nack_in1), .busy(busy1), .done(donef1), .error(err1));

  logic [15:0] rom0 [64];
  logic [15:0] rom1 [4];
  always @(posedge clk) rom_data0 <= rom0[rom_addr0];
  always @(posedge clk) rom_data1 <= rom1[rom_addr1];

  // Master 0: acks 10 cycles after req rises; NACKs entry nack_addr up to nack_limit times
  int cyc = 0;
  int nack_addr = -1, nack_limit = 0, nacks_given = 0;
  int m_cnt0 = 0, ep0 = 0, dn0 = 0;
  logic req0_q = 1'b0;
  logic [7:0] ep_reg [8];
  logic [7:0] ep_wd  [8];
  int ep_rise [8];
  int ep_fall [8];
  int done_cyc [8];

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_cnt0 <= 0; done_in0 <= 1'b0; nack_in0 <= 1'b0; req0_q <= 1'b0;
    end else begin
      cyc      <= cyc + 1;
      req0_q   <= req0;
      done_in0 <= 1'b0;
      nack_in0 <= 1'b0;
      if (req0 && !req0_q) begin
        if (ep0 < 8) begin
          ep_reg[ep0] <= reg0; ep_wd[ep0] <= wd0; ep_rise[ep0] <= cyc;
        end
        ep0 <= ep0 + 1;
      end
      if (!req0 && req0_q && ep0 > 0 && ep0 <= 8) ep_fall[ep0-1] <= cyc;
      if (req0 && !done_in0) begin
        if (m_cnt0 == 9) begin
          m_cnt0   <= 0;
          done_in0 <= 1'b1;
          if (int'(rom_addr0) == nack_addr && nacks_given < nack_limit) begin
            nack_in0    <= 1'b1;
            nacks_given <= nacks_given + 1;
          end
          if (dn0 < 8) done_cyc[dn0] <= cyc + 1;
          dn0 <= dn0 + 1;
        end else begin
          m_cnt0 <= m_cnt0 + 1;
        end
      end else begin
        m_cnt0 <= 0;
      end
      if (tb_clr) begin
        ep0 <= 0; dn0 <= 0; nacks_given <= 0;
      end
    end
  end

  // Master 1: acks 3 cycles after req rises, never NACKs
  int m_cnt1 = 0, ep1 = 0;
  logic req1_q = 1'b0;
  logic [7:0] last_reg1 = 8'h00;
  always @(posedge clk or posedge res) begin
    if (res) begin
      m_cnt1 <= 0; done_in1 <= 1'b0; nack_in1 <= 1'b0; req1_q <= 1'b0;
    end else begin
      req1_q   <= req1;
      done_in1 <= 1'b0;
      nack_in1 <= 1'b0;
      if (req1 && !req1_q) begin
        ep1 <= ep1 + 1; last_reg1 <= reg1;
      end
      if (req1 && !done_in1) begin
        if (m_cnt1 == 2) begin m_cnt1 <= 0; done_in1 <= 1'b1; end
        else m_cnt1 <= m_cnt1 + 1;
      end else begin
        m_cnt1 <= 0;
      end
      if (tb_clr) ep1 <= 0;
    end
  end

  int tests = 0, fails = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    tb_clr = 1'b1; @(negedge clk); tb_clr = 1'b0;
  endtask

  // Returns at the cycle-1 negedge after the start pulse
  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!(sel ? busy1 : busy0)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic fill_rom0();
    for (int i = 0; i < 64; i++) rom0[i] = 16'hFFFF;
  endtask

  task automatic test_reset();
    tick(2);
    tests++;
    if ({req0, busy0, donef0, err0, rom_addr0, reg0, wd0} !== 28'h0) begin
      fails++; $display("FAIL reset_u0: req=%b busy=%b done=%b err=%b addr=%0d reg=%h wd=%h, want all 0",
                        req0, busy0, donef0, err0, rom_addr0, reg0, wd0);
    end
    tests++;
    if ({req1, busy1, donef1, err1, rom_addr1} !== 6'h0) begin
      fails++; $display("FAIL reset_u1: req=%b busy=%b done=%b err=%b addr=%0d, want all 0",
                        req1, busy1, donef1, err1, rom_addr1);
    end
    tests++;
    if (dev0 !== 8'h42) begin fails++; $display("FAIL dev_addr: got %h want 42", dev0); end
    res = 1'b0;
    tick(1);
  endtask

  task automatic test_two_writes();
    bit ok;
    fill_rom0();
    rom0[0] = 16'h1280; rom0[1] = 16'h1101;
    nack_addr = -1; nack_limit = 0;
    clear_log();
    pulse_start(1'b0);
    tests++;
    if (busy0 !== 1'b1 || rom_addr0 !== 6'd0) begin
      fails++; $display("FAIL start_cycle1: busy=%b addr=%0d, want busy=1 addr=0", busy0, rom_addr0);
    end
    tick(1);
    tests++;
    if (req0 !== 1'b0) begin fails++; $display("FAIL req_cycle2: got %b want 0", req0); end
    tick(1);
    tests++;
    if (req0 !== 1'b1 || reg0 !== 8'h12 || wd0 !== 8'h80) begin
      fails++; $display("FAIL req_cycle3: req=%b reg=%h wd=%h, want 1/12/80", req0, reg0, wd0);
    end
    wait_idle(1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL two_writes_timeout: busy still %b, want 0", busy0); end
    tests++;
    if (ep0 !== 2 || ep_reg[0] !== 8'h12 || ep_wd[0] !== 8'h80 || ep_reg[1] !== 8'h11 || ep_wd[1] !== 8'h01) begin
      fails++; $display("FAIL two_writes_data: eps=%0d (%h,%h) (%h,%h), want 2 (12,80) (11,01)",
                        ep0, ep_reg[0], ep_wd[0], ep_reg[1], ep_wd[1]);
    end
    tests++;
    if (ep_rise[1] - done_cyc[0] !== 3) begin
      fails++; $display("FAIL ack_to_next_req: got %0d cycles want 3", ep_rise[1] - done_cyc[0]);
    end
    tests++;
    if (donef0 !== 1'b1 || err0 !== 1'b0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL two_writes_flags: done=%b err=%b busy=%b, want 1/0/0", donef0, err0, busy0);
    end
  endtask

  task automatic test_delay();
    bit ok;
    fill_rom0();
    rom0[0] = 16'h1280; rom0[1] = 16'hFFF0; rom0[2] = 16'h40D0;
    clear_log();
    pulse_start(1'b0);
    wait_idle(1'b0, ok);
    tests++;
    if (!ok || ep0 !== 2 || ep_reg[1] !== 8'h40 || ep_wd[1] !== 8'hD0 || donef0 !== 1'b1) begin
      fails++; $display("FAIL delay_table: ok=%b eps=%0d reg=%h wd=%h done=%b, want 1/2/40/D0/1",
                        ok, ep0, ep_reg[1], ep_wd[1], donef0);
    end
    // done(n) -> FETCH n+1, DECODE n+2, DELAY n+3..n+102, FETCH n+103, DECODE n+104, req n+105
    tests++;
    if (ep_rise[1] - done_cyc[0] !== 105) begin
      fails++; $display("FAIL delay_gap: got %0d cycles want 105", ep_rise[1] - done_cyc[0]);
    end
  endtask

  task automatic test_retry();
    bit ok;
    fill_rom0();
    rom0[0] = 16'h3A04;
    nack_addr = 0; nack_limit = 2;
    clear_log();
    pulse_start(1'b0);
    wait_idle(1'b0, ok);
    tests++;
    if (!ok || ep0 !== 3 || ep_reg[2] !== 8'h3A || ep_wd[2] !== 8'h04) begin
      fails++; $display("FAIL retry_count: ok=%b eps=%0d reg=%h wd=%h, want 1/3/3A/04", ok, ep0, ep_reg[2], ep_wd[2]);
    end
    tests++;
    if (ep_rise[1] - ep_fall[0] !== 1 || ep_rise[2] - ep_fall[1] !== 1) begin
      fails++; $display("FAIL retry_gap: got %0d,%0d low cycles want 1,1",
                        ep_rise[1] - ep_fall[0], ep_rise[2] - ep_fall[1]);
    end
    tests++;
    if (donef0 !== 1'b1 || err0 !== 1'b0) begin
      fails++; $display("FAIL retry_flags: done=%b err=%b want 1/0", donef0, err0);
    end
  endtask

  task automatic test_error();
    bit ok;
    fill_rom0();
    for (int i = 0; i < 6; i++) rom0[i] = {8'h20 + 8'(i), 8'h10 + 8'(i)};
    nack_addr = 5; nack_limit = 4;
    clear_log();
    pulse_start(1'b0);
    wait_idle(1'b0, ok);
    tests++;
    if (!ok || err0 !== 1'b1 || donef0 !== 1'b0 || rom_addr0 !== 6'd5 || busy0 !== 1'b0) begin
      fails++; $display("FAIL error_flags: ok=%b err=%b done=%b addr=%0d busy=%b, want 1/1/0/5/0",
                        ok, err0, donef0, rom_addr0, busy0);
    end
    tests++;
    if (ep0 !== 9) begin fails++; $display("FAIL error_attempts: got %0d want 9", ep0); end
    nack_limit = 0;
    clear_log();
    pulse_start(1'b0);
    tests++;
    if (err0 !== 1'b0 || rom_addr0 !== 6'd0 || busy0 !== 1'b1) begin
      fails++; $display("FAIL restart_after_error: err=%b addr=%0d busy=%b, want 0/0/1", err0, rom_addr0, busy0);
    end
    wait_idle(1'b0, ok);
    tests++;
    if (!ok || donef0 !== 1'b1 || ep0 !== 6) begin
      fails++; $display("FAIL rerun_complete: ok=%b done=%b eps=%0d, want 1/1/6", ok, donef0, ep0);
    end
  endtask

  task automatic test_no_end();
    bit ok;
    rom1[0] = 16'hA101; rom1[1] = 16'hA202; rom1[2] = 16'hA303; rom1[3] = 16'hA404;
    clear_log();
    pulse_start(1'b1);
    wait_idle(1'b1, ok);
    tests++;
    if (!ok || ep1 !== 4 || last_reg1 !== 8'hA4 || donef1 !== 1'b1 || err1 !== 1'b0) begin
      fails++; $display("FAIL no_end_table: ok=%b eps=%0d last=%h done=%b err=%b, want 1/4/A4/1/0",
                        ok, ep1, last_reg1, donef1, err1);
    end
    tick(20);
    tests++;
    if (rom_addr1 !== 2'd3) begin fails++; $display("FAIL no_wrap: addr=%0d want 3", rom_addr1); end
    pulse_start(1'b1);
    tests++;
    if (rom_addr1 !== 2'd0 || busy1 !== 1'b1 || donef1 !== 1'b0) begin
      fails++; $display("FAIL no_end_restart: addr=%0d busy=%b done=%b, want 0/1/0", rom_addr1, busy1, donef1);
    end
    wait_idle(1'b1, ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    fill_rom0();
    rom0[0] = 16'h1280; rom0[1] = 16'h1101;
    clear_log();
    pulse_start(1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rom_addr0 == 6'd1 && req0) break;
    end
    tick(2);
    #2 res = 1'b1;
    #1;
    tests++;
    if ({req0, busy0, donef0, err0, rom_addr0, reg0, wd0} !== 28'h0) begin
      fails++; $display("FAIL async_reset: req=%b busy=%b done=%b err=%b addr=%0d reg=%h wd=%h, want all 0",
                        req0, busy0, donef0, err0, rom_addr0, reg0, wd0);
    end
    @(negedge clk);
    res = 1'b0;
    clear_log();
    pulse_start(1'b0);
    tests++;
    if (rom_addr0 !== 6'd0 || busy0 !== 1'b1) begin
      fails++; $display("FAIL start_after_reset: addr=%0d busy=%b, want 0/1", rom_addr0, busy0);
    end
    tick(1);
    pulse_start(1'b0);
    wait_idle(1'b0, ok);
    tests++;
    if (!ok || ep0 !== 2 || ep_reg[0] !== 8'h12 || ep_reg[1] !== 8'h11 || donef0 !== 1'b1) begin
      fails++; $display("FAIL start_while_busy: ok=%b eps=%0d regs=%h,%h done=%b, want 1/2/12,11/1",
                        ok, ep0, ep_reg[0], ep_reg[1], donef0);
    end
  endtask

  initial begin
    fill_rom0();
    for (int i = 0; i < 4; i++) rom1[i] = 16'hFFFF;
    test_reset();
    test_two_writes();
    test_delay();
    test_retry();
    test_error();
    test_no_end();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
